// File: rtl/mem_word_access.sv
// mem_word_access
//   Sequences one 16-bit CPU load/store into two byte accesses on a
//   byte-wide memory with a combinational read port: low byte at addr,
//   high byte at addr+1 (little-endian, address wraps modulo 2^ADDR_WIDTH).
//
//   Optional build macro: MEM_WORD_ACCESS_BYTE_EN
//     Adds input byte_sel (latched with req). byte_sel=1 performs a
//     single low-byte access (LO -> DONE); loads return {8'h00, byte}.
//
// Ports
//   clk, rst          clock / asynchronous active-high reset
//   req, we           request (sampled in IDLE only), 1=store 0=load
//   addr, wdata       low-byte address and store data, latched with req
//   rdata             load result, held until the next load completes
//   busy, done        busy while not IDLE; done pulses one cycle per access
//   mem_addr, mem_din memory address / write data
//   mem_read, mem_write memory strobes
//   mem_dout          memory read data (only sampled while mem_read=1)
module mem_word_access #(
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [15:0]           wdata,
`ifdef MEM_WORD_ACCESS_BYTE_EN
  input  logic                  byte_sel,
`endif
  output logic [15:0]           rdata,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_din,
  output logic                  mem_read,
  output logic                  mem_write,
  input  logic [7:0]            mem_dout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                  state;
  state_t                  state_nxt;

  logic [ADDR_WIDTH-1:0]   addr_l;
  logic [15:0]             wdata_l;
  logic                    we_l;
  logic [7:0]              rdata_tmp;
  logic                    byte_only;

`ifdef MEM_WORD_ACCESS_BYTE_EN
  logic                    byte_sel_l;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_sel_l <= 1'b0;
    end else if (state == IDLE && req) begin
      byte_sel_l <= byte_sel;
    end
  end

  assign byte_only = byte_sel_l;
`else
  assign byte_only = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = LO;
      LO:      state_nxt = byte_only ? DONE : HI;
      HI:      state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch and read-data capture. mem_dout is only looked at in
  // LO/HI of a load, so an undriven bus elsewhere never reaches rdata, and
  // rdata only changes when the final byte of a load arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_l    <= '0;
      wdata_l   <= '0;
      we_l      <= 1'b0;
      rdata_tmp <= '0;
      rdata     <= '0;
    end else begin
      if (state == IDLE && req) begin
        addr_l  <= addr;
        wdata_l <= wdata;
        we_l    <= we;
      end
      if (state == LO && !we_l) begin
        if (byte_only) begin
          rdata <= {8'h00, mem_dout};
        end else begin
          rdata_tmp <= mem_dout;
        end
      end
      if (state == HI && !we_l) begin
        rdata <= {mem_dout, rdata_tmp};
      end
    end
  end

  // Output decode; memory strobes are only active in LO/HI and mem_din is
  // zero whenever no write is in progress.
  always_comb begin
    busy      = (state != IDLE);
    done      = (state == DONE);
    mem_addr  = addr_l;
    mem_din   = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    case (state)
      LO: begin
        mem_read  = ~we_l;
        mem_write = we_l;
        mem_din   = we_l ? wdata_l[7:0] : '0;
      end
      HI: begin
        mem_addr  = addr_l + ADDR_WIDTH'(1);
        mem_read  = ~we_l;
        mem_write = we_l;
        mem_din   = we_l ? wdata_l[15:8] : '0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_word_access.sv
// tb_mem_word_access
//   Testbench for mem_word_access with a byte-wide memory model
//   (combinational read, write on rising edge). Expected load results are
//   queued when an access is issued and compared when done pulses.
module tb_mem_word_access;

  logic        clk;
  logic        rst;
  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [15:0] wdata;
`ifdef MEM_WORD_ACCESS_BYTE_EN
  logic        byte_sel;
`endif
  logic [15:0] rdata;
  logic        busy;
  logic        done;
  logic [15:0] mem_addr;
  logic [7:0]  mem_din;
  logic        mem_read;
  logic        mem_write;
  logic [7:0]  mem_dout;

  logic [7:0]  mem [65536];

  int          checks;
  int          failures;
  logic [15:0] sb[$];
  logic [15:0] model_rdata;
  logic        load_active;
  int          addr40_cnt;
  int          wr_load_cnt;

  mem_word_access #(.ADDR_WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
`ifdef MEM_WORD_ACCESS_BYTE_EN
    .byte_sel  (byte_sel),
`endif
    .rdata     (rdata),
    .busy      (busy),
    .done      (done),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_dout  (mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(input int unsigned i);
    return 8'((i * 37) + 11);
  endfunction

  // Memory model; 8'hDE stands in for the undriven bus when not reading
  assign mem_dout = mem_read ? mem[mem_addr] : 8'hDE;

  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_din;
  end

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor: idle strobes, scoreboard on done, illegal address/write flags
  always @(negedge clk) begin
    if (!rst) begin
      if (!busy) check_eq("idle_ctrl", {22'd0, mem_read, mem_write, mem_din}, 32'd0);
      if (busy && mem_addr == 16'h0040) addr40_cnt <= addr40_cnt + 1;
      if (mem_write && load_active) wr_load_cnt <= wr_load_cnt + 1;
      if (done) begin
        check_eq("done_expected", {31'd0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) check_eq("rdata", {16'd0, rdata}, {16'd0, sb.pop_front()});
      end
    end
  end

  task automatic do_access(input logic w, input logic [15:0] a,
                           input logic [15:0] d, input logic bs,
                           input logic [15:0] exp_load);
    int lat;
    int wr_before;
    int exp_lat;
    exp_lat = bs ? 2 : 3;
    @(negedge clk);
    req   = 1'b1;
    we    = w;
    addr  = a;
    wdata = d;
`ifdef MEM_WORD_ACCESS_BYTE_EN
    byte_sel = bs;
`endif
    if (!w) model_rdata = exp_load;
    sb.push_back(model_rdata);
    load_active = !w;
    wr_before   = wr_load_cnt;
    @(posedge clk);
    #1 req = 1'b0;
    addr  = 16'h0040;
    wdata = 16'hFFFF;
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      lat++;
      if (done) break;
    end
    check_eq(w ? "store_latency" : "load_latency", lat, exp_lat);
    if (!w) check_eq("no_write_in_load", wr_load_cnt - wr_before, 0);
    load_active = 1'b0;
`ifdef MEM_WORD_ACCESS_BYTE_EN
    byte_sel = 1'b0;
`endif
  endtask

  initial begin
    logic [15:0] exp;
    int          a40_before;
    checks = 0; failures = 0;
    model_rdata = '0; load_active = 1'b0;
    addr40_cnt = 0; wr_load_cnt = 0;
    for (int unsigned i = 0; i < 65536; i++) mem[i] <= init_byte(i);
    rst = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
`ifdef MEM_WORD_ACCESS_BYTE_EN
    byte_sel = 1'b0;
`endif

    // Asynchronous reset, mid-cycle
    #2 rst = 1'b1;
    #1;
    check_eq("rst_rdata", {16'd0, rdata}, 32'd0);
    check_eq("rst_addr", {16'd0, mem_addr}, 32'd0);
    check_eq("rst_ctrl", {20'd0, busy, done, mem_read, mem_write, mem_din}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("idle_busy", {31'd0, busy}, 32'd0);
    end

    // Word store then load
    do_access(1'b1, 16'h0010, 16'hBEEF, 1'b0, 16'h0);
    check_eq("mem_0010", {24'd0, mem[16'h0010]}, 32'h00EF);
    check_eq("mem_0011", {24'd0, mem[16'h0011]}, 32'h00BE);
    do_access(1'b0, 16'h0010, 16'h0, 1'b0, 16'hBEEF);

    // Address wrap
    do_access(1'b1, 16'hFFFF, 16'h1234, 1'b0, 16'h0);
    check_eq("mem_ffff", {24'd0, mem[16'hFFFF]}, 32'h0034);
    check_eq("mem_0000", {24'd0, mem[16'h0000]}, 32'h0012);
    do_access(1'b0, 16'hFFFF, 16'h0, 1'b0, 16'h1234);

    // Requests while busy are ignored
    a40_before = addr40_cnt;
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 16'h0020; wdata = 16'h0;
    exp = {init_byte(16'h0021), init_byte(16'h0020)};
    model_rdata = exp;
    sb.push_back(exp);
    load_active = 1'b1;
    @(posedge clk);
    #1 addr = 16'h0040;
    @(negedge clk); req = 1'b0;
    @(negedge clk); req = 1'b1;
    @(negedge clk);
    check_eq("busy_done", {31'd0, done}, 32'd1);
    req = 1'b0;
    load_active = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clk);
    check_eq("addr40_never", addr40_cnt - a40_before, 0);

    // Reset during the high byte of a store
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 16'h0030; wdata = 16'hAA55;
    @(posedge clk);
    #1 req = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("midrst_ctrl", {20'd0, busy, done, mem_read, mem_write, mem_din}, 32'd0);
    check_eq("midrst_addr", {16'd0, mem_addr}, 32'd0);
    check_eq("midrst_rdata", {16'd0, rdata}, 32'd0);
    model_rdata = '0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("mem_0030", {24'd0, mem[16'h0030]}, 32'h0055);
    check_eq("mem_0031", {24'd0, mem[16'h0031]}, {24'd0, init_byte(16'h0031)});
    check_eq("midrst_rdata_after", {16'd0, rdata}, 32'd0);

`ifdef MEM_WORD_ACCESS_BYTE_EN
    // Single-byte store and load
    do_access(1'b1, 16'h0050, 16'h77CC, 1'b1, 16'h0);
    check_eq("mem_0050", {24'd0, mem[16'h0050]}, 32'h00CC);
    check_eq("mem_0051", {24'd0, mem[16'h0051]}, {24'd0, init_byte(16'h0051)});
    do_access(1'b0, 16'h0050, 16'h0, 1'b1, 16'h00CC);
    do_access(1'b0, 16'h0050, 16'h0, 1'b0, {init_byte(16'h0051), 8'hCC});
`endif

    // Store leaves rdata alone; then a plain load of untouched memory
    do_access(1'b1, 16'h0100, 16'hC3A5, 1'b0, 16'h0);
    do_access(1'b0, 16'h0200, 16'h0, 1'b0,
              {init_byte(16'h0201), init_byte(16'h0200)});

    repeat (3) @(negedge clk);
    check_eq("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
